// File: rtl/drive_pkg.sv
// ============================================================================
// Module  : drive_pkg
// Brief   : Shared types and helpers for the camera-driven steering block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package drive_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SEARCH      = 3'd1,
    ST_FORWARD     = 3'd2,
    ST_TRACK_LEFT  = 3'd3,
    ST_TRACK_RIGHT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OBS_NONE   = 2'd0,
    OBS_LEFT   = 2'd1,
    OBS_RIGHT  = 2'd2,
    OBS_CENTER = 2'd3
  } obs_t;

  // Centered beats turns; a left/right conflict reads as no observation.
  function automatic obs_t obs_decode(input logic centered,
                                      input logic turn_left,
                                      input logic turn_right);
    if (centered)                      return OBS_CENTER;
    else if (turn_left && !turn_right) return OBS_LEFT;
    else if (turn_right && !turn_left) return OBS_RIGHT;
    else                               return OBS_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/drive_steer_ctrl_pwm_gen.sv
// ============================================================================
// Module  : pwm_gen
// Brief   : Free-running PWM with duty latched at period wrap (or on demand).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_gen #(
  parameter int PERIOD = 1000,
  parameter int DW     = $clog2(PERIOD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] duty,
  input  logic          load_en,
  output logic          pwm,
  output logic          wrap
);

  logic [DW-1:0] r_pcnt;
  logic [DW-1:0] r_duty;
  logic          r_pwm;

  assign wrap = (r_pcnt == DW'(PERIOD - 1));
  assign pwm  = r_pwm;

  // load_en bypasses the wrap so a forced-zero duty reaches the pin next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= '0;
      r_duty <= '0;
      r_pwm  <= 1'b0;
    end else begin
      r_pcnt <= wrap ? '0 : r_pcnt + DW'(1);
      if (load_en || wrap) r_duty <= duty;
      r_pwm <= load_en ? (r_pcnt < duty) : (r_pcnt < r_duty);
    end
  end

endmodule

`default_nettype wire

// File: rtl/drive_steer_ctrl.sv
// ============================================================================
// Module  : drive_steer_ctrl
// Brief   : Debounces per-frame camera flags into a steering state and drives
//           two wheel PWMs plus direction bits.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module drive_steer_ctrl
  import drive_pkg::*;
#(
  parameter int PWM_PERIOD     = 1000,
  parameter int DUTY_FWD       = 600,
  parameter int DUTY_FAST      = 700,
  parameter int DUTY_SLOW      = 300,
  parameter int DUTY_SEARCH    = 400,
  parameter int CONFIRM_FRAMES = 3,
  parameter int LOST_FRAMES    = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic       turn_left,
  input  logic       turn_right,
  input  logic       centered,
  output logic       pwm_left,
  output logic       pwm_right,
  output logic       dir_left,
  output logic       dir_right,
  output logic [2:0] state_out,
  output logic       lost
);

  localparam int c_dw = $clog2(PWM_PERIOD + 1);
  localparam int c_cw = $clog2(CONFIRM_FRAMES + 1);
  localparam int c_lw = $clog2(LOST_FRAMES + 1);
  localparam logic [c_cw-1:0] c_cnt_max  = c_cw'(CONFIRM_FRAMES);
  localparam logic [c_lw-1:0] c_lost_max = c_lw'(LOST_FRAMES);

  if (DUTY_FWD > PWM_PERIOD || DUTY_FAST > PWM_PERIOD ||
      DUTY_SLOW > PWM_PERIOD || DUTY_SEARCH > PWM_PERIOD) begin : g_duty_range_err
    $error("drive_steer_ctrl: a duty parameter exceeds PWM_PERIOD");
  end

  state_t          r_state, w_state_nxt, w_target;
  obs_t            r_cand, w_cand_nxt, w_obs;
  logic [c_cw-1:0] r_cnt, w_cnt_nxt, w_cnt_upd;
  logic [c_lw-1:0] r_lost_cnt, w_lost_nxt, w_lost_upd;
  logic            w_commit;

  logic [c_dw-1:0] w_tab_l, w_tab_r, w_duty_l, w_duty_r;
  logic            w_tab_dl, w_tab_dr;
  logic            r_dir_l, r_dir_r;
  logic            w_wrap, w_wrap_l, w_wrap_r;

  always_comb begin
    w_obs      = obs_decode(centered, turn_left, turn_right);
    w_cnt_upd  = (w_obs != r_cand)      ? c_cw'(1) :
                 (r_cnt == c_cnt_max)   ? r_cnt    : r_cnt + c_cw'(1);
    w_lost_upd = (w_obs != OBS_NONE)        ? '0         :
                 (r_lost_cnt == c_lost_max) ? r_lost_cnt : r_lost_cnt + c_lw'(1);
    w_commit   = (w_cnt_upd == c_cnt_max) && (w_obs != OBS_NONE);
    case (w_obs)
      OBS_CENTER: w_target = ST_FORWARD;
      OBS_LEFT:   w_target = ST_TRACK_LEFT;
      OBS_RIGHT:  w_target = ST_TRACK_RIGHT;
      default:    w_target = r_state;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_lost_nxt  = r_lost_cnt;
    if (!enable || r_state == ST_IDLE) begin
      w_state_nxt = enable ? ST_SEARCH : ST_IDLE;
      w_cand_nxt  = OBS_NONE;
      w_cnt_nxt   = '0;
      w_lost_nxt  = '0;
    end else if (frame_tick) begin
      w_cand_nxt = w_obs;
      w_cnt_nxt  = w_cnt_upd;
      w_lost_nxt = w_lost_upd;
      if (r_state != ST_SEARCH && w_lost_upd == c_lost_max)
        w_state_nxt = ST_SEARCH;
      else if (w_commit)
        w_state_nxt = w_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cand     <= OBS_NONE;
      r_cnt      <= '0;
      r_lost_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cand     <= w_cand_nxt;
      r_cnt      <= w_cnt_nxt;
      r_lost_cnt <= w_lost_nxt;
    end
  end

  always_comb begin
    w_tab_l  = '0;
    w_tab_r  = '0;
    w_tab_dl = 1'b1;
    w_tab_dr = 1'b1;
    case (r_state)
      ST_FORWARD: begin
        w_tab_l = c_dw'(DUTY_FWD);
        w_tab_r = c_dw'(DUTY_FWD);
      end
      ST_TRACK_LEFT: begin
        w_tab_l = c_dw'(DUTY_SLOW);
        w_tab_r = c_dw'(DUTY_FAST);
      end
      ST_TRACK_RIGHT: begin
        w_tab_l = c_dw'(DUTY_FAST);
        w_tab_r = c_dw'(DUTY_SLOW);
      end
      ST_SEARCH: begin
        w_tab_l  = c_dw'(DUTY_SEARCH);
        w_tab_r  = c_dw'(DUTY_SEARCH);
        w_tab_dr = 1'b0;
      end
      default: ;
    endcase
  end

  // Dropping enable zeroes the duties at once instead of waiting for the wrap.
  assign w_duty_l = enable ? w_tab_l : '0;
  assign w_duty_r = enable ? w_tab_r : '0;

  // Both counters run in lockstep from reset, so their wraps coincide.
  assign w_wrap = w_wrap_l & w_wrap_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dir_l <= 1'b1;
      r_dir_r <= 1'b1;
    end else if (!enable) begin
      r_dir_l <= 1'b1;
      r_dir_r <= 1'b1;
    end else if (w_wrap) begin
      r_dir_l <= w_tab_dl;
      r_dir_r <= w_tab_dr;
    end
  end

  pwm_gen #(.PERIOD(PWM_PERIOD), .DW(c_dw)) u_pwm_left (
    .clk     (clk),
    .rst     (rst),
    .duty    (w_duty_l),
    .load_en (!enable),
    .pwm     (pwm_left),
    .wrap    (w_wrap_l)
  );

  pwm_gen #(.PERIOD(PWM_PERIOD), .DW(c_dw)) u_pwm_right (
    .clk     (clk),
    .rst     (rst),
    .duty    (w_duty_r),
    .load_en (!enable),
    .pwm     (pwm_right),
    .wrap    (w_wrap_r)
  );

  assign dir_left  = r_dir_l;
  assign dir_right = r_dir_r;
  assign state_out = r_state;
  assign lost      = (r_state == ST_SEARCH);

endmodule

`default_nettype wire
